pc_inc_logic: RTL and testbench
===============================

PC_INC_LOGIC -- requirements
Module: pc_inc_logic

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: CLK and RST.
REQ-002 CLK  input  1  clock; all state updates on rising edge.
REQ-003 RST  input  1  asynchronous active-high reset; acts immediately, independent of CLK.
REQ-004 I_PC  input  1  increment request; 1 = next PC is select value + 1.
REQ-005 PCLS_DATA  input  8  low byte from the PC low select register.
REQ-006 PCHS_DATA  input  8  high byte from the PC high select register.
REQ-007 DATA_IN  input  8  memory read data used during vector fetch.
REQ-008 VEC_READY  input  1  memory handshake: DATA_IN valid for current VEC_ADDR.
REQ-009 PCL_OUT  output  8  registered PC low byte; feeds the PCL register DATA input.
REQ-010 PCH_OUT  output  8  registered PC high byte; feeds the PCH register.
REQ-011 VEC_ADDR  output  16  registered vector fetch address.
REQ-012 VEC_REQ  output  1  registered; 1 = vector fetch in progress, memory read requested.
REQ-013 RUN  output  1  registered; 1 = normal increment operation.
REQ-014 PAGE_CROSS  output  1  registered one-cycle pulse: carry propagated from low into high byte.

Function
REQ-015 SHALL implement a 3-state FSM: VEC_LO, VEC_HI, RUN; encoding free; no other reachable states.
REQ-016 In VEC_LO: VEC_REQ=1, VEC_ADDR=16'hFFFC, RUN=0.
REQ-017 VEC_LO, VEC_READY=1 at edge -> PCL_OUT<=DATA_IN, VEC_ADDR<=16'hFFFD, state<=VEC_HI; VEC_READY=0 -> hold all outputs.
REQ-018 VEC_HI, VEC_READY=1 at edge -> PCH_OUT<=DATA_IN, VEC_REQ<=0, RUN<=1, state<=RUN; VEC_READY=0 -> hold.
REQ-019 Vector fetch SHALL take exactly 2 handshaken cycles; wait cycles (VEC_READY=0) unbounded, no timeout.
REQ-020 I_PC, PCLS_DATA, PCHS_DATA SHALL be ignored in VEC_LO/VEC_HI; PAGE_CROSS=0 there.
REQ-021 In RUN, every edge: {PCH_OUT,PCL_OUT} <= {PCHS_DATA,PCLS_DATA} + I_PC, 16-bit, unconditional (PC reloads from select registers every cycle).
REQ-022 I_PC=0 -> outputs equal select inputs (pure copy, 1-cycle latency).
REQ-023 Carry: PCLS_DATA=8'hFF with I_PC=1 -> PCL_OUT<=8'h00, PCH_OUT<=PCHS_DATA+1 in the same edge.
REQ-024 Wrap: 16'hFFFF + 1 -> 16'h0000, no overflow flag, no state change.
REQ-025 PAGE_CROSS <= RUN & I_PC & (PCLS_DATA==8'hFF); high exactly one cycle per qualifying edge, consecutive qualifying edges give consecutive highs.
REQ-026 In RUN: VEC_READY and DATA_IN ignored; VEC_REQ stays 0; VEC_ADDR holds 16'hFFFD.
REQ-027 RUN is terminal; only RST leaves it.
REQ-028 All outputs SHALL be driven from flops; no combinational path from inputs to outputs.

Reset
REQ-029 RST=1 SHALL immediately force: state VEC_LO, PCL_OUT=8'h00, PCH_OUT=8'h00, VEC_ADDR=16'hFFFC, VEC_REQ=1, RUN=0, PAGE_CROSS=0.
REQ-030 Outputs SHALL hold reset values while RST=1 regardless of CLK and inputs.
REQ-031 RST asserted mid-fetch or in RUN SHALL abort and restart the vector fetch from VEC_LO; no partial PC retained.
REQ-032 First state change after RST deassert SHALL occur at the first rising CLK edge with VEC_READY=1.

Verification
REQ-033 Reset, then VEC_READY=1 with DATA_IN=8'h34, next edge DATA_IN=8'h12 -> PCL_OUT=8'h34, PCH_OUT=8'h12, RUN=1, VEC_REQ=0 after 2 edges.
REQ-034 VEC_READY=0 for 5 cycles in VEC_HI -> VEC_ADDR=16'hFFFD, outputs frozen; then VEC_READY=1 completes fetch.
REQ-035 RUN, PCHS/PCLS=8'h12/8'hFF, I_PC=1 -> PCH/PCL_OUT=8'h13/8'h00, PAGE_CROSS=1 for one cycle; next edge with PCLS=8'h00 -> PAGE_CROSS=0.
REQ-036 RUN, select=16'hFFFF, I_PC=1 -> PC_OUT=16'h0000, PAGE_CROSS=1, RUN stays 1.
REQ-037 RUN, select=16'hABCD, I_PC=0 -> PC_OUT=16'hABCD; toggling VEC_READY/DATA_IN has no effect.
REQ-038 RST pulsed asynchronously between edges in RUN -> outputs reach reset values before next edge; fetch restarts at 16'hFFFC.

Source files
------------

// File: rtl/pc_inc_logic_if.sv
// PC increment bus: select/vector inputs toward the PC logic, registered PC/fetch status back.
// master drives requests and select bytes; slave is the PC logic itself.
interface pc_inc_logic_if;
    logic        i_pc;
    logic [7:0]  pcls_data;
    logic [7:0]  pchs_data;
    logic [7:0]  data_in;
    logic        vec_ready;
    logic [7:0]  pcl_out;
    logic [7:0]  pch_out;
    logic [15:0] vec_addr;
    logic        vec_req;
    logic        run;
    logic        page_cross;

    modport master (
        output i_pc, pcls_data, pchs_data, data_in, vec_ready,
        input  pcl_out, pch_out, vec_addr, vec_req, run, page_cross
    );

    modport slave (
        input  i_pc, pcls_data, pchs_data, data_in, vec_ready,
        output pcl_out, pch_out, vec_addr, vec_req, run, page_cross
    );
endinterface

// File: rtl/pc_inc_logic.sv
// Reset-vector fetch then PC reload/increment; all outputs registered, 1-cycle latency.
// Vector fetch stalls indefinitely while vec_ready is low; RUN never stalls.
module pc_inc_logic (
    input  logic           clk,
    input  logic           rst,
    pc_inc_logic_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_VEC_LO = 2'd0,
        ST_VEC_HI = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t      state_q, state_d;

    logic [7:0]  pcl_q, pcl_d;
    logic [7:0]  pch_q, pch_d;
    logic [15:0] addr_q, addr_d;
    logic        req_q, req_d;
    logic        run_q, run_d;
    logic        page_q, page_d;
    logic [15:0] pc_sum;

    assign pc_sum = {bus.pchs_data, bus.pcls_data} + {15'd0, bus.i_pc};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_VEC_LO;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_VEC_LO: if (bus.vec_ready) state_d = ST_VEC_HI;
            ST_VEC_HI: if (bus.vec_ready) state_d = ST_RUN;
            ST_RUN:    state_d = ST_RUN;
            default:   state_d = ST_VEC_LO;
        endcase
    end

    // Next values of the output flops; hold unless the current state updates them.
    always_comb begin
        pcl_d  = pcl_q;
        pch_d  = pch_q;
        addr_d = addr_q;
        req_d  = req_q;
        run_d  = run_q;
        page_d = 1'b0;
        case (state_q)
            ST_VEC_LO: begin
                if (bus.vec_ready) begin
                    pcl_d  = bus.data_in;
                    addr_d = 16'hFFFD;
                end
            end
            ST_VEC_HI: begin
                if (bus.vec_ready) begin
                    pch_d = bus.data_in;
                    req_d = 1'b0;
                    run_d = 1'b1;
                end
            end
            ST_RUN: begin
                {pch_d, pcl_d} = pc_sum;
                page_d         = bus.i_pc & (bus.pcls_data == 8'hFF);
            end
            default: begin
                pcl_d  = 8'h00;
                pch_d  = 8'h00;
                addr_d = 16'hFFFC;
                req_d  = 1'b1;
                run_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcl_q  <= 8'h00;
            pch_q  <= 8'h00;
            addr_q <= 16'hFFFC;
            req_q  <= 1'b1;
            run_q  <= 1'b0;
            page_q <= 1'b0;
        end else begin
            pcl_q  <= pcl_d;
            pch_q  <= pch_d;
            addr_q <= addr_d;
            req_q  <= req_d;
            run_q  <= run_d;
            page_q <= page_d;
        end
    end

    assign bus.pcl_out    = pcl_q;
    assign bus.pch_out    = pch_q;
    assign bus.vec_addr   = addr_q;
    assign bus.vec_req    = req_q;
    assign bus.run        = run_q;
    assign bus.page_cross = page_q;
endmodule

// File: tb/tb_pc_inc_logic.sv
// Randomized bench for pc_inc_logic against a rule-level reference model.
module tb_pc_inc_logic;
    logic clk;
    logic rst;
    pc_inc_logic_if bus();

    pc_inc_logic dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: phase 0 = fetching low byte, 1 = high byte, 2 = running.
    int          m_phase;
    int unsigned m_pc;
    logic [15:0] m_addr;
    logic        m_req, m_run, m_page;

    function automatic logic [34:0] exp_vec();
        logic [15:0] pc16;
        pc16 = m_pc[15:0];
        return {pc16, m_addr, m_req, m_run, m_page};
    endfunction

    function automatic logic [34:0] got_vec();
        return {bus.pch_out, bus.pcl_out, bus.vec_addr, bus.vec_req, bus.run, bus.page_cross};
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_pc    = 0;
        m_addr  = 16'hFFFC;
        m_req   = 1'b1;
        m_run   = 1'b0;
        m_page  = 1'b0;
    endtask

    task automatic model_edge();
        m_page = 1'b0;
        if (m_phase == 0) begin
            if (bus.vec_ready) begin
                m_pc    = (m_pc & 32'hFF00) | 32'(bus.data_in);
                m_addr  = 16'hFFFD;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (bus.vec_ready) begin
                m_pc    = (m_pc & 32'h00FF) | (32'(bus.data_in) * 256);
                m_req   = 1'b0;
                m_run   = 1'b1;
                m_phase = 2;
            end
        end else begin
            m_page = bus.i_pc && (bus.pcls_data == 8'hFF);
            m_pc   = (32'(bus.pchs_data) * 256 + 32'(bus.pcls_data) + 32'(bus.i_pc)) % 65536;
        end
    endtask

    // Advance one edge, update model with the inputs seen at that edge, settle.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        model_reset();
        #1;
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
    endtask

    task automatic rand_inputs();
        bus.i_pc      = 1'($urandom);
        bus.pcls_data = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
        bus.pchs_data = ($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom);
        bus.data_in   = 8'($urandom);
        bus.vec_ready = 1'($urandom);
    endtask

    task automatic fetch(input logic [7:0] lo, input logic [7:0] hi);
        bus.vec_ready = 1'b1;
        bus.data_in   = lo;
        tick();
        bus.data_in   = hi;
        tick();
        bus.vec_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        #3;
        tests_run++;
        if (got_vec() !== exp_vec()) begin
            tests_failed++;
            $display("FAIL reset_values got=%h exp=%h", got_vec(), exp_vec());
        end
        for (int i = 0; i < 4; i++) begin
            rand_inputs();
            bus.vec_ready = 1'b1;
            @(posedge clk);
            #1;
            tests_run++;
            if (got_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL reset_hold[%0d] got=%h exp=%h", i, got_vec(), exp_vec());
            end
        end
        bus.vec_ready = 1'b0;
        #3 rst = 1'b0;
        #1;
    endtask

    task automatic test_vector_fetch();
        do_reset();
        bus.vec_ready = 1'b1;
        bus.data_in   = 8'h34;
        bus.i_pc      = 1'b1;
        bus.pcls_data = 8'hFF;
        tick();
        tests_run++;
        if (got_vec() !== exp_vec() || bus.pcl_out !== 8'h34 || bus.vec_addr !== 16'hFFFD) begin
            tests_failed++;
            $display("FAIL fetch_lo got=%h exp=%h", got_vec(), exp_vec());
        end
        bus.data_in = 8'h12;
        tick();
        tests_run++;
        if (got_vec() !== exp_vec() || {bus.pch_out, bus.pcl_out} !== 16'h1234 ||
            bus.run !== 1'b1 || bus.vec_req !== 1'b0 || bus.page_cross !== 1'b0) begin
            tests_failed++;
            $display("FAIL fetch_done got=%h exp=%h", got_vec(), exp_vec());
        end
        bus.vec_ready = 1'b0;
    endtask

    task automatic test_wait_states();
        do_reset();
        for (int i = 0; i < 30; i++) begin
            rand_inputs();
            tick();
            tests_run++;
            if (got_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL fetch_random_wait[%0d] got=%h exp=%h", i, got_vec(), exp_vec());
            end
            if (m_phase == 1) break;
        end
        bus.vec_ready = (m_phase == 0);
        bus.data_in   = 8'h5A;
        if (m_phase == 0) tick();
        bus.vec_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.data_in = 8'($urandom);
            bus.i_pc    = 1'($urandom);
            tick();
            tests_run++;
            if (got_vec() !== exp_vec() || bus.vec_addr !== 16'hFFFD || bus.vec_req !== 1'b1) begin
                tests_failed++;
                $display("FAIL vec_hi_wait[%0d] got=%h exp=%h", i, got_vec(), exp_vec());
            end
        end
        bus.vec_ready = 1'b1;
        bus.data_in   = 8'hC3;
        tick();
        tests_run++;
        if (got_vec() !== exp_vec() || bus.pch_out !== 8'hC3 || bus.run !== 1'b1) begin
            tests_failed++;
            $display("FAIL vec_hi_complete got=%h exp=%h", got_vec(), exp_vec());
        end
        bus.vec_ready = 1'b0;
    endtask

    task automatic test_carry();
        bus.pchs_data = 8'h12;
        bus.pcls_data = 8'hFF;
        bus.i_pc      = 1'b1;
        tick();
        tests_run++;
        if (got_vec() !== exp_vec() || {bus.pch_out, bus.pcl_out} !== 16'h1300 || bus.page_cross !== 1'b1) begin
            tests_failed++;
            $display("FAIL carry got=%h exp=%h", got_vec(), exp_vec());
        end
        bus.pcls_data = 8'h00;
        tick();
        tests_run++;
        if (got_vec() !== exp_vec() || bus.page_cross !== 1'b0 || {bus.pch_out, bus.pcl_out} !== 16'h1201) begin
            tests_failed++;
            $display("FAIL carry_next got=%h exp=%h", got_vec(), exp_vec());
        end
    endtask

    task automatic test_wrap();
        bus.pchs_data = 8'hFF;
        bus.pcls_data = 8'hFF;
        bus.i_pc      = 1'b1;
        tick();
        tests_run++;
        if (got_vec() !== exp_vec() || {bus.pch_out, bus.pcl_out} !== 16'h0000 ||
            bus.page_cross !== 1'b1 || bus.run !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap got=%h exp=%h", got_vec(), exp_vec());
        end
        tick();
        tests_run++;
        if (got_vec() !== exp_vec() || bus.page_cross !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap_consecutive got=%h exp=%h", got_vec(), exp_vec());
        end
    endtask

    task automatic test_copy_ignore();
        bus.pchs_data = 8'hAB;
        bus.pcls_data = 8'hCD;
        bus.i_pc      = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.vec_ready = 1'($urandom);
            bus.data_in   = 8'($urandom);
            tick();
            tests_run++;
            if (got_vec() !== exp_vec() || {bus.pch_out, bus.pcl_out} !== 16'hABCD ||
                bus.vec_req !== 1'b0 || bus.vec_addr !== 16'hFFFD) begin
                tests_failed++;
                $display("FAIL copy_ignore[%0d] got=%h exp=%h", i, got_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random_run();
        for (int i = 0; i < 300; i++) begin
            rand_inputs();
            tick();
            tests_run++;
            if (got_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL random_run[%0d] got=%h exp=%h", i, got_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        model_reset();
        #1;
        tests_run++;
        if (got_vec() !== exp_vec()) begin
            tests_failed++;
            $display("FAIL async_reset_run got=%h exp=%h", got_vec(), exp_vec());
        end
        #1 rst = 1'b0;
        bus.vec_ready = 1'b1;
        bus.data_in   = 8'h77;
        tick();
        tests_run++;
        if (got_vec() !== exp_vec() || bus.pcl_out !== 8'h77 || bus.vec_addr !== 16'hFFFD) begin
            tests_failed++;
            $display("FAIL restart_fetch got=%h exp=%h", got_vec(), exp_vec());
        end
        #2 rst = 1'b1;
        model_reset();
        #1;
        tests_run++;
        if (got_vec() !== exp_vec()) begin
            tests_failed++;
            $display("FAIL async_reset_mid_fetch got=%h exp=%h", got_vec(), exp_vec());
        end
        #1 rst = 1'b0;
        bus.vec_ready = 1'b0;
        tick();
        tests_run++;
        if (got_vec() !== exp_vec() || bus.vec_addr !== 16'hFFFC) begin
            tests_failed++;
            $display("FAIL post_reset_idle got=%h exp=%h", got_vec(), exp_vec());
        end
    endtask

    initial begin
        rst           = 1'b0;
        bus.i_pc      = 1'b0;
        bus.pcls_data = 8'h00;
        bus.pchs_data = 8'h00;
        bus.data_in   = 8'h00;
        bus.vec_ready = 1'b0;
        model_reset();

        test_reset();
        test_vector_fetch();
        test_wait_states();
        test_carry();
        test_wrap();
        test_copy_ignore();
        test_random_run();
        test_async_reset();
        do_reset();
        fetch(8'($urandom), 8'($urandom));
        test_random_run();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
